// File: rtl/fetch_buffer_stage.sv
// Instruction fetch front end: issues in-order fetch requests, absorbs the
// responses into a small first-word-fall-through queue and presents the head to decode.
module fetch_buffer_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INS    = 32'h00000013
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      PCSrc_E,
    input  logic [ADDR_WIDTH-1:0]     PCTarget_E,
    output logic                      imem_req_valid_o,
    input  logic                      imem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]     imem_req_addr_o,
    input  logic                      imem_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0]     imem_rsp_data_i,
    input  logic                      IF_ID_Write,
    output logic                      Valid_D,
    output logic [DATA_WIDTH-1:0]     Ins_D,
    output logic [ADDR_WIDTH-1:0]     PC_D,
    output logic [ADDR_WIDTH-1:0]     PC_4D,
    output logic [$clog2(DEPTH):0]    fill_level_o
);

    localparam int                    PW      = $clog2(DEPTH);
    localparam int                    CW      = PW + 1;
    localparam logic [CW:0]           DEPTH_L = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0]         CNT_ONE = CW'(1);
    localparam logic [PW-1:0]         PTR_ONE = PW'(1);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    logic [ADDR_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
    logic [ADDR_WIDTH-1:0] rsp_pc_reg, rsp_pc_next;
    logic [CW-1:0]         outstanding_reg, outstanding_next;
    logic [CW-1:0]         drop_reg, drop_next;
    logic [CW-1:0]         count_reg, count_next;
    logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;

    logic [DATA_WIDTH-1:0] ins_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem  [DEPTH];

    logic [CW:0] occ_sum;
    logic        req_valid;
    logic        req_fire;
    logic        drop_active;
    logic        rsp_keep;
    logic        head_valid;
    logic        pop;

    // Requests are throttled by queue slots already promised to in-flight fetches.
    assign occ_sum     = {1'b0, count_reg} + {1'b0, outstanding_reg};
    assign req_valid   = !rst && !PCSrc_E && (occ_sum < DEPTH_L);
    assign req_fire    = req_valid && imem_req_ready_i;
    assign drop_active = (drop_reg != '0);
    assign rsp_keep    = imem_rsp_valid_i && !drop_active && !PCSrc_E && !rst;
    assign head_valid  = !rst && (count_reg != '0);
    assign pop         = head_valid && IF_ID_Write && !PCSrc_E;

    always_comb begin
        outstanding_next = outstanding_reg;
        case ({req_fire, imem_rsp_valid_i})
            2'b10:   outstanding_next = outstanding_reg + CNT_ONE;
            2'b01:   outstanding_next = outstanding_reg - CNT_ONE;
            default: outstanding_next = outstanding_reg;
        endcase
    end

    // A redirect marks every fetch still in flight (beyond this cycle's response) as stale.
    always_comb begin
        drop_next = drop_reg;
        if (PCSrc_E) begin
            drop_next = outstanding_reg - CW'(imem_rsp_valid_i);
        end else if (imem_rsp_valid_i && drop_active) begin
            drop_next = drop_reg - CNT_ONE;
        end
    end

    always_comb begin
        count_next  = count_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        if (PCSrc_E) begin
            count_next  = '0;
            rd_ptr_next = wr_ptr_reg;
        end else begin
            if (rsp_keep) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            case ({rsp_keep, pop})
                2'b10:   count_next = count_reg + CNT_ONE;
                2'b01:   count_next = count_reg - CNT_ONE;
                default: count_next = count_reg;
            endcase
        end
    end

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        rsp_pc_next   = rsp_pc_reg;
        if (PCSrc_E) begin
            fetch_pc_next = PCTarget_E;
            rsp_pc_next   = PCTarget_E;
        end else begin
            if (req_fire) begin
                fetch_pc_next = fetch_pc_reg + PC_STEP;
            end
            if (rsp_keep) begin
                rsp_pc_next = rsp_pc_reg + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg    <= RESET_PC;
            rsp_pc_reg      <= RESET_PC;
            outstanding_reg <= '0;
            drop_reg        <= '0;
            count_reg       <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            rsp_pc_reg      <= rsp_pc_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
            count_reg       <= count_next;
            rd_ptr_reg      <= rd_ptr_next;
            wr_ptr_reg      <= wr_ptr_next;
        end
    end

    // Queue slots carry no reset; occupancy alone decides what is visible.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rsp_keep && (wr_ptr_reg == PW'(gi))) begin
                    ins_mem[gi] <= imem_rsp_data_i;
                    pc_mem[gi]  <= rsp_pc_reg;
                end
            end
        end
    endgenerate

    assign imem_req_valid_o = req_valid;
    assign imem_req_addr_o  = fetch_pc_reg;
    assign Valid_D          = head_valid;
    assign Ins_D            = head_valid ? ins_mem[rd_ptr_reg] : NOP_INS;
    assign PC_D             = head_valid ? pc_mem[rd_ptr_reg] : '0;
    assign PC_4D            = head_valid ? (pc_mem[rd_ptr_reg] + PC_STEP) : '0;
    assign fill_level_o     = rst ? '0 : count_reg;

endmodule

// File: tb/tb_fetch_buffer_stage.sv
// Bench for fetch_buffer_stage: in-order memory model with variable latency and a
// program-order scoreboard of the PCs decode must see.
module tb_fetch_buffer_stage;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] XMASK = 32'hA5A5_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          PCSrc_E;
    logic [AW-1:0] PCTarget_E;
    logic          imem_req_valid_o;
    logic          imem_req_ready_i;
    logic [AW-1:0] imem_req_addr_o;
    logic          imem_rsp_valid_i;
    logic [DW-1:0] imem_rsp_data_i;
    logic          IF_ID_Write;
    logic          Valid_D;
    logic [DW-1:0] Ins_D;
    logic [AW-1:0] PC_D;
    logic [AW-1:0] PC_4D;
    logic [2:0]    fill_level_o;

    always #5 clk = ~clk;

    fetch_buffer_stage #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
        .RESET_PC(32'h0), .NOP_INS(NOP)
    ) dut (
        .clk(clk), .rst(rst), .PCSrc_E(PCSrc_E), .PCTarget_E(PCTarget_E),
        .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
        .imem_req_addr_o(imem_req_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i),
        .imem_rsp_data_i(imem_rsp_data_i), .IF_ID_Write(IF_ID_Write),
        .Valid_D(Valid_D), .Ins_D(Ins_D), .PC_D(PC_D), .PC_4D(PC_4D),
        .fill_level_o(fill_level_o)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
    } mem_t;

    mem_t        mem_q[$];
    logic [31:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] cyc = 0;
    logic [31:0] last_due = 0;
    int          lat = 1;
    int          pops = 0;
    logic [31:0] exp_fetch = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = 0;
    logic        s_valid, s_reqv;
    logic [2:0]  s_fill;
    logic [31:0] s_pc, s_pc4, s_ins, s_addr;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: present the memory response, sample at negedge, update models after posedge.
    task automatic cycle();
        logic        fire, pop, rsp;
        logic [31:0] e, t, due;
        rsp = !rst && (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        imem_rsp_valid_i = rsp;
        imem_rsp_data_i  = rsp ? (mem_q[0].addr ^ XMASK) : '0;
        @(negedge clk);
        s_valid = Valid_D; s_reqv = imem_req_valid_o; s_fill = fill_level_o;
        s_pc = PC_D; s_pc4 = PC_4D; s_ins = Ins_D; s_addr = imem_req_addr_o;
        if (rst) begin
            check_val("rst_valid_d", Valid_D, 0);
            check_val("rst_fill", fill_level_o, 0);
        end
        if (rst || PCSrc_E) check_val("req_valid_off", imem_req_valid_o, 0);
        if (prev_stall && !rst && !PCSrc_E) begin
            check_val("hold_valid", imem_req_valid_o, 1);
            check_val("hold_addr", imem_req_addr_o, prev_addr);
        end
        check_val("fill_range", (fill_level_o > 3'(DEPTH)), 0);
        if (!Valid_D) begin
            check_val("bubble_ins", Ins_D, NOP);
            check_val("bubble_pc", PC_D, 0);
            check_val("bubble_pc4", PC_4D, 0);
        end
        fire = imem_req_valid_o && imem_req_ready_i;
        pop  = Valid_D && IF_ID_Write && !PCSrc_E && !rst;
        if (fire) begin
            check_val("req_addr", imem_req_addr_o, exp_fetch);
            due = cyc + 32'(lat);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{addr: imem_req_addr_o, due: due});
            exp_q.push_back(exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (pop) begin
            pops++;
            $display("dec  pc=%08h ins=%08h fill=%0d", PC_D, Ins_D, fill_level_o);
            if (exp_q.size() == 0) begin
                check_val("spurious_pop", 1, 0);
            end else begin
                e = exp_q.pop_front();
                t = e + 32'd4;
                check_val("dec_pc", PC_D, e);
                check_val("dec_pc4", PC_4D, t);
                check_val("dec_ins", Ins_D, e ^ XMASK);
            end
        end
        if (rsp) void'(mem_q.pop_front());
        prev_stall = imem_req_valid_o && !imem_req_ready_i;
        prev_addr  = imem_req_addr_o;
        if (rst) begin
            mem_q.delete(); exp_q.delete();
            exp_fetch = 32'h0; prev_stall = 1'b0;
        end else if (PCSrc_E) begin
            $display("redir target=%08h", PCTarget_E);
            exp_q.delete();
            exp_fetch = PCTarget_E;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; PCSrc_E = 1'b0;
        cycle(); cycle();
        rst = 1'b0;
    endtask

    task automatic wait_head(input string tag, input logic [31:0] want);
        int n = 0;
        while (!s_valid && n < 30) begin cycle(); n++; end
        check_val({tag, "_seen"}, s_valid, 1);
        check_val({tag, "_pc"}, s_pc, want);
        check_val({tag, "_pc4"}, s_pc4, want + 32'd4);
    endtask

    initial begin
        int          first_valid, n, inflight;
        logic [31:0] held;
        rst = 1'b1; PCSrc_E = 1'b0; PCTarget_E = '0; imem_req_ready_i = 1'b1;
        IF_ID_Write = 1'b1; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
        repeat (3) cycle();
        check_val("rst_ins", s_ins, NOP);
        check_val("rst_pc", s_pc, 0);
        rst = 1'b0;

        // streaming, 1-cycle memory latency
        pops = 0; first_valid = -1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (first_valid < 0 && s_valid) first_valid = i;
        end
        check_val("stream_first_valid", first_valid, 2);
        check_val("stream_pops", pops, 18);

        // decode stalled until the queue saturates
        do_reset();
        IF_ID_Write = 1'b0;
        repeat (10) cycle();
        check_val("full_fill", s_fill, 4);
        check_val("full_req_valid", s_reqv, 0);
        IF_ID_Write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_val("drain_valid", s_valid, 1);
            check_val("drain_pc", s_pc, 32'(i * 4));
        end
        repeat (4) cycle();

        // redirect with two fetches still in flight
        do_reset();
        lat = 3; n = 0;
        do begin
            inflight = mem_q.size() - (((mem_q.size() != 0) && (mem_q[0].due <= cyc)) ? 1 : 0);
            if (inflight != 2) begin cycle(); n++; end
        end while (inflight != 2 && n < 30);
        check_val("inflight_reached", inflight, 2);
        PCSrc_E = 1'b1; PCTarget_E = 32'h100;
        cycle();
        PCSrc_E = 1'b0;
        cycle();
        check_val("redir_fill", s_fill, 0);
        check_val("redir_req_next", s_reqv, 1);
        check_val("redir_req_addr", s_addr, 32'h100);
        wait_head("redir2", 32'h100);

        // back-to-back redirects: the last target wins
        PCSrc_E = 1'b1; PCTarget_E = 32'h200; cycle();
        PCTarget_E = 32'h300; cycle();
        PCSrc_E = 1'b0;
        cycle();
        wait_head("redir_last", 32'h300);

        // redirect colliding with a response and a pop
        do_reset();
        lat = 1;
        repeat (6) cycle();
        PCSrc_E = 1'b1; PCTarget_E = 32'h40;
        cycle();
        PCSrc_E = 1'b0;
        cycle();
        check_val("collide_fill", s_fill, 0);
        check_val("collide_valid", s_valid, 0);
        check_val("collide_ins", s_ins, NOP);
        check_val("collide_req", s_reqv, 1);
        repeat (6) cycle();

        // memory backpressure for three cycles
        imem_req_ready_i = 1'b0;
        cycle(); held = s_addr;
        repeat (2) begin
            cycle();
            check_val("bp_addr_held", s_addr, held);
        end
        imem_req_ready_i = 1'b1;
        repeat (8) cycle();

        // reset while three entries are queued
        IF_ID_Write = 1'b0; n = 0;
        while (fill_level_o != 3'd3 && n < 30) begin cycle(); n++; end
        check_val("fill3_reached", fill_level_o, 3);
        rst = 1'b1;
        cycle();
        rst = 1'b0; IF_ID_Write = 1'b1;
        cycle();
        check_val("post_rst_valid", s_valid, 0);
        check_val("post_rst_fill", s_fill, 0);
        check_val("post_rst_req", s_reqv, 1);
        check_val("post_rst_addr", s_addr, 32'h0);
        repeat (5) cycle();

        // randomized traffic including address wraparound
        for (int i = 0; i < 400; i++) begin
            lat = $urandom_range(1, 3);
            imem_req_ready_i = ($urandom_range(0, 3) != 0);
            IF_ID_Write = ($urandom_range(0, 9) < 7);
            PCSrc_E = ($urandom_range(0, 29) == 0) || (i == 200);
            PCTarget_E = (i == 200) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            cycle();
        end

        // drain: nothing new issued, everything expected must reach decode
        PCSrc_E = 1'b0; imem_req_ready_i = 1'b0; IF_ID_Write = 1'b1; n = 0;
        while ((mem_q.size() != 0 || Valid_D) && n < 60) begin cycle(); n++; end
        check_val("drain_done", (mem_q.size() == 0) && !Valid_D, 1);
        check_val("no_loss", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_buffer_stage.md
FETCH_BUFFER_STAGE -- requirements
Module: fetch_buffer_stage

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 32, meaning PC/address width.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, meaning instruction width.
REQ-003 The module SHALL have parameter DEPTH, default 4, meaning instruction-queue entries (power of 2, >=2).
REQ-004 The module SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-005 The module SHALL have parameter NOP_INS, default 32'h00000013, meaning the bubble instruction.
REQ-006 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1, SHALL be the reset: synchronous, active-high.
REQ-008 Port PCSrc_E, input, 1, SHALL be the redirect/flush request from execute.
REQ-009 Port PCTarget_E, input, ADDR_WIDTH, SHALL be the redirect target.
REQ-010 Port imem_req_valid_o, output, 1, SHALL be the fetch-request valid.
REQ-011 Port imem_req_ready_i, input, 1, SHALL be the memory accept.
REQ-012 Port imem_req_addr_o, output, ADDR_WIDTH, SHALL be the fetch address.
REQ-013 Port imem_rsp_valid_i, input, 1, SHALL be the response valid; responses are in order, at least 1 cycle after acceptance.
REQ-014 Port imem_rsp_data_i, input, DATA_WIDTH, SHALL be the response instruction.
REQ-015 Port IF_ID_Write, input, 1, SHALL be the decode-ready signal; 0 means stall.
REQ-016 Port Valid_D, output, 1, SHALL indicate that Ins_D/PC_D/PC_4D hold a real instruction.
REQ-017 Ports Ins_D (DATA_WIDTH), PC_D and PC_4D (ADDR_WIDTH), outputs, SHALL carry the queue-head instruction, its PC and its PC+4.
REQ-018 Port fill_level_o, output, $clog2(DEPTH)+1, SHALL report queue occupancy.

Function
REQ-019 A request SHALL fire when imem_req_valid_o && imem_req_ready_i; fetch_pc SHALL then advance by 4, modulo 2^ADDR_WIDTH.
REQ-020 imem_req_valid_o SHALL be 1 iff !rst && !PCSrc_E && (occupancy + outstanding) < DEPTH, so the queue can never overflow.
REQ-021 imem_req_addr_o SHALL equal fetch_pc; addr and valid SHALL hold stable while valid && !ready.
REQ-022 An outstanding counter SHALL be +1 on request fire and -1 on each response (kept and dropped alike); both events in the same cycle leave it unchanged.
REQ-023 A drop counter SHALL count in-flight responses made stale by a redirect; while it is nonzero, each response decrements it and is discarded.
REQ-024 A kept response SHALL push {data, rsp_pc} into the queue; rsp_pc SHALL then advance by 4.
REQ-025 The queue SHALL be first-word-fall-through: Valid_D = (occupancy != 0), and head fields are visible combinationally.
REQ-026 Pop SHALL occur when Valid_D && IF_ID_Write && !PCSrc_E; push and pop in the same cycle leave occupancy unchanged.
REQ-027 When Valid_D=0, Ins_D SHALL be NOP_INS and PC_D and PC_4D SHALL be 0.
REQ-028 On PCSrc_E=1, the following SHALL hold for that cycle:
- The queue SHALL be emptied and no pop SHALL occur.
- No request SHALL be issued.
- Any response arriving that cycle SHALL be dropped.
- fetch_pc and rsp_pc SHALL load PCTarget_E.
- The drop counter SHALL load (outstanding - imem_rsp_valid_i).
REQ-029 After a redirect, the first request to PCTarget_E SHALL be issued the next cycle, subject to REQ-020.
REQ-030 Consecutive redirect cycles SHALL each reapply REQ-028; the last target wins.
REQ-031 PC_4D SHALL equal PC_D + 4 (wrapping) whenever Valid_D=1.

Reset
REQ-032 When rst=1 at a clock edge, the following SHALL be cleared or set:
- The queue, outstanding counter and drop counter SHALL be cleared.
- fetch_pc and rsp_pc SHALL be set to RESET_PC.
REQ-033 While rst=1, imem_req_valid_o SHALL be 0 and Valid_D, fill_level_o, PC_D and PC_4D SHALL be 0, with Ins_D = NOP_INS.
REQ-034 rst SHALL override PCSrc_E; reset mid-transaction SHALL leave no responses marked for dropping, and the memory is reset alongside.

Verification
REQ-035 Streaming: ready=1, 1-cycle response latency, IF_ID_Write=1, data=PC^32'hA5A5_0000 -> Valid_D rises 2 cycles after reset release; PC_D sequence is 0,4,8,...; Ins_D matches.
REQ-036 Stall-full: IF_ID_Write=0 -> fill_level_o saturates at 4 and imem_req_valid_o drops to 0; on release, 4 pops occur back-to-back with PC 0,4,8,12 and no loss or duplicate.
REQ-037 Redirect with 2 responses in flight, PCTarget_E=0x100 -> the next 2 responses are dropped; the next Valid_D shows PC_D=0x100, PC_4D=0x104.
REQ-038 Redirect in the same cycle as a response and a pop -> the response is dropped; fill_level_o is 0 the next cycle; Ins_D=0x00000013.
REQ-039 Backpressure: imem_req_ready_i=0 for 3 cycles -> imem_req_addr_o is held constant and no duplicate PCs appear at decode.
REQ-040 Reset asserted mid-stream with 3 queued entries -> the next cycle shows Valid_D=0 and fill_level_o=0; the first request after release is to RESET_PC.
